if_pd_skid_seg: RTL and testbench

//  Parametrised elastic IF->PD pipeline segment replacing the fixed stall/refresh register.
//  - Holds up to DEPTH fetched-instruction entries (pc, addr_error, bd, predictor payload) in a circular buffer.
//  - Uses valid/ready handshakes on both sides, so fetch continues while PD back-pressures.
//  - Derives the branch-delay-slot flag internally and computes pc+PC_INC per entry.

---
 rtl/if_pd_skid_seg.sv | 110 +++++++++++
 tb/tb_if_pd_skid_seg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/if_pd_skid_seg.sv
// Elastic IF->PD pipeline segment: a DEPTH-entry circular buffer of fetched
// instructions with valid/ready on both sides and an internally derived delay-slot flag.
module if_pd_skid_seg #(
  parameter int          DEPTH  = 2,
  parameter int          DW     = 48,
  parameter logic [31:0] PC_INC = 32'd8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_pc,
  input  logic                         in_addr_error,
  input  logic                         in_branch,
  input  logic [DW-1:0]                in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_pc,
  output logic [31:0]                  out_pc_8,
  output logic                         out_bd,
  output logic                         out_addr_error,
  output logic [DW-1:0]                out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_pc8  [DEPTH];
  logic          mem_bd   [DEPTH];
  logic          mem_ae   [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt_q;
  logic          last_branch;
  logic          push;
  logic          pop;

  // Handshake: a transfer happens on a side when valid & ready are both high at
  // the rising edge. in_ready depends only on registered occupancy, so a full
  // buffer refuses input even while PD pops in the same cycle.
  assign in_ready  = (cnt_q < CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = cnt_q;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      last_branch <= 1'b0;
    end else if (flush) begin
      cnt_q       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      last_branch <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr      <= ptr_next(wr_ptr);
        last_branch <= in_branch;
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Payload storage needs no reset: it is only observed while out_valid is high.
  always_ff @(posedge clk) begin
    if (resetn && !flush && push) begin
      mem_pc[wr_ptr]   <= in_pc;
      mem_pc8[wr_ptr]  <= in_pc + PC_INC;
      mem_bd[wr_ptr]   <= last_branch;
      mem_ae[wr_ptr]   <= in_addr_error;
      mem_data[wr_ptr] <= in_data;
    end
  end

  always_comb begin
    out_pc         = '0;
    out_pc_8       = '0;
    out_bd         = 1'b0;
    out_addr_error = 1'b0;
    out_data       = '0;
    if (out_valid) begin
      out_pc         = mem_pc[rd_ptr];
      out_pc_8       = mem_pc8[rd_ptr];
      out_bd         = mem_bd[rd_ptr];
      out_addr_error = mem_ae[rd_ptr];
      out_data       = mem_data[rd_ptr];
    end
  end

endmodule

// File: tb/tb_if_pd_skid_seg.sv
// Bench for if_pd_skid_seg: DEPTH=2 and DEPTH=3 instances share stimulus and are
// checked against a queue-based model; a vector table pins down the directed cases.
module tb_if_pd_skid_seg;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, in_branch, in_addr_error, out_ready;
  logic [31:0] in_pc;
  logic [47:0] in_data;

  logic        r2, v2, bd2, ae2;
  logic [31:0] pc2, pc82;
  logic [47:0] d2;
  logic [1:0]  cnt2;
  logic        r3, v3, bd3, ae3;
  logic [31:0] pc3, pc83;
  logic [47:0] d3;
  logic [1:0]  cnt3;

  int checks = 0;
  int errors = 0;
  string phase = "init";

  always #5 clk = ~clk;

  if_pd_skid_seg #(.DEPTH(2), .DW(48), .PC_INC(32'd8)) dut2 (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(r2), .in_pc(in_pc),
    .in_addr_error(in_addr_error), .in_branch(in_branch), .in_data(in_data),
    .out_valid(v2), .out_ready(out_ready), .out_pc(pc2), .out_pc_8(pc82),
    .out_bd(bd2), .out_addr_error(ae2), .out_data(d2), .count(cnt2)
  );

  if_pd_skid_seg #(.DEPTH(3), .DW(48), .PC_INC(32'd8)) dut3 (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(r3), .in_pc(in_pc),
    .in_addr_error(in_addr_error), .in_branch(in_branch), .in_data(in_data),
    .out_valid(v3), .out_ready(out_ready), .out_pc(pc3), .out_pc_8(pc83),
    .out_bd(bd3), .out_addr_error(ae3), .out_data(d3), .count(cnt3)
  );

  // Reference model: one plain queue of accepted entries per instance.
  typedef struct packed {
    logic [31:0] pc;
    logic        bd;
    logic        ae;
    logic [47:0] data;
  } ent_t;

  ent_t mq [2][$];
  logic lb [2];
  int   dep [2];

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!resetn || flush) begin
        mq[k].delete();
        lb[k] = 1'b0;
      end else begin
        bit rdy, pu, po;
        ent_t e;
        rdy = (mq[k].size() < dep[k]);
        pu  = in_valid && rdy;
        po  = (mq[k].size() > 0) && out_ready;
        if (po) void'(mq[k].pop_front());
        if (pu) begin
          e.pc = in_pc; e.bd = lb[k]; e.ae = in_addr_error; e.data = in_data;
          mq[k].push_back(e);
          lb[k] = in_branch;
        end
      end
    end
  endtask

  // {out_valid, pc, pc_8, bd, addr_error, data, count(8), in_ready}
  function automatic logic [123:0] expected(int k);
    ent_t e;
    logic ov;
    e  = '0;
    ov = (mq[k].size() > 0);
    if (ov) e = mq[k][0];
    return {ov, e.pc, ov ? e.pc + 32'd8 : 32'd0, e.bd, e.ae, e.data,
            8'(mq[k].size()), 1'(mq[k].size() < dep[k])};
  endfunction

  function automatic logic [123:0] actual(int k);
    if (k == 0) return {v2, pc2, pc82, bd2, ae2, d2, 6'd0, cnt2, r2};
    else        return {v3, pc3, pc83, bd3, ae3, d3, 6'd0, cnt3, r3};
  endfunction

  task automatic chk(input string name, input logic [123:0] got, input logic [123:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s [%s] got=%h exp=%h", name, phase, got, exp);
    end
  endtask

  task automatic step(input logic rn, input logic fl, input logic iv, input logic br,
                      input logic [31:0] pc, input logic ae, input logic [47:0] d,
                      input logic ordy);
    resetn = rn; flush = fl; in_valid = iv; in_branch = br;
    in_pc = pc; in_addr_error = ae; in_data = d; out_ready = ordy;
    @(posedge clk);
    model_edge();
    #1;
    chk("model_depth2", actual(0), expected(0));
    chk("model_depth3", actual(1), expected(1));
  endtask

  typedef struct packed {
    logic        rn, fl, iv, br;
    logic [31:0] pc;
    logic        ordy;
    logic        ov;
    logic [31:0] opc, opc8;
    logic        obd;
    logic [7:0]  cnt;
    logic        irdy;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(logic rn, logic fl, logic iv, logic br, logic [31:0] pc,
                              logic ordy, logic ov, logic [31:0] opc, logic [31:0] opc8,
                              logic obd, logic [7:0] cnt, logic irdy);
    vec_t v;
    v.rn = rn; v.fl = fl; v.iv = iv; v.br = br; v.pc = pc; v.ordy = ordy;
    v.ov = ov; v.opc = opc; v.opc8 = opc8; v.obd = obd; v.cnt = cnt; v.irdy = irdy;
    return v;
  endfunction

  initial begin
    dep[0] = 2; dep[1] = 3;
    lb[0] = 1'b0; lb[1] = 1'b0;

    //             rn fl iv br pc             ordy ov opc            opc8           bd cnt irdy
    tbl[0]  = mk(0, 0, 0, 0, 32'h0,         1, 0, 32'h0,        32'h0,        0, 0, 1);
    tbl[1]  = mk(1, 0, 1, 0, 32'hBFC00000,  1, 1, 32'hBFC00000, 32'hBFC00008, 0, 1, 1);
    tbl[2]  = mk(1, 0, 0, 0, 32'h0,         1, 0, 32'h0,        32'h0,        0, 0, 1);
    tbl[3]  = mk(1, 0, 1, 0, 32'h100,       0, 1, 32'h100,      32'h108,      0, 1, 1);
    tbl[4]  = mk(1, 0, 1, 0, 32'h104,       0, 1, 32'h100,      32'h108,      0, 2, 0);
    tbl[5]  = mk(1, 0, 1, 0, 32'h108,       0, 1, 32'h100,      32'h108,      0, 2, 0);
    tbl[6]  = mk(1, 0, 0, 0, 32'h0,         1, 1, 32'h104,      32'h10C,      0, 1, 1);
    tbl[7]  = mk(1, 0, 0, 0, 32'h0,         1, 0, 32'h0,        32'h0,        0, 0, 1);
    tbl[8]  = mk(1, 0, 1, 1, 32'h200,       0, 1, 32'h200,      32'h208,      0, 1, 1);
    tbl[9]  = mk(1, 0, 0, 0, 32'h0,         0, 1, 32'h200,      32'h208,      0, 1, 1);
    tbl[10] = mk(1, 0, 1, 0, 32'h204,       0, 1, 32'h200,      32'h208,      0, 2, 0);
    tbl[11] = mk(1, 0, 0, 0, 32'h0,         1, 1, 32'h204,      32'h20C,      1, 1, 1);
    tbl[12] = mk(1, 0, 0, 0, 32'h0,         1, 0, 32'h0,        32'h0,        0, 0, 1);
    tbl[13] = mk(1, 0, 1, 1, 32'h300,       0, 1, 32'h300,      32'h308,      0, 1, 1);
    tbl[14] = mk(1, 0, 1, 1, 32'h304,       0, 1, 32'h300,      32'h308,      0, 2, 0);
    tbl[15] = mk(1, 1, 1, 0, 32'h308,       0, 0, 32'h0,        32'h0,        0, 0, 1);
    tbl[16] = mk(1, 0, 1, 0, 32'h400,       0, 1, 32'h400,      32'h408,      0, 1, 1);
    tbl[17] = mk(1, 1, 0, 0, 32'h0,         0, 0, 32'h0,        32'h0,        0, 0, 1);
    tbl[18] = mk(1, 0, 1, 1, 32'h500,       0, 1, 32'h500,      32'h508,      0, 1, 1);
    tbl[19] = mk(1, 0, 1, 1, 32'h504,       0, 1, 32'h500,      32'h508,      0, 2, 0);
    tbl[20] = mk(0, 0, 1, 0, 32'h508,       0, 0, 32'h0,        32'h0,        0, 0, 1);
    tbl[21] = mk(1, 0, 1, 0, 32'h600,       0, 1, 32'h600,      32'h608,      0, 1, 1);
    tbl[22] = mk(1, 1, 0, 0, 32'h0,         0, 0, 32'h0,        32'h0,        0, 0, 1);

    phase = "reset_hold";
    step(0, 0, 0, 0, 32'h0, 0, 48'h0, 0);

    phase = "table";
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].rn, tbl[i].fl, tbl[i].iv, tbl[i].br, tbl[i].pc, 1'b0,
           {16'hA5A5, tbl[i].pc}, tbl[i].ordy);
      chk($sformatf("vec%0d_depth2", i),
          124'({v2, pc2, pc82, bd2, 6'd0, cnt2, r2}),
          124'({tbl[i].ov, tbl[i].opc, tbl[i].opc8, tbl[i].obd, tbl[i].cnt, tbl[i].irdy}));
    end

    // Continuous push with out_ready toggling across pointer wrap, then drain.
    phase = "wrap_d3";
    for (int i = 0; i < 9; i++)
      step(1, 0, 1, i[0], 32'h700 + 32'(4 * i), 0, 48'(i), i[0]);
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 0, 32'h0, 0, 48'h0, 1);

    phase = "pc_wrap";
    step(1, 1, 0, 0, 32'h0, 0, 48'h0, 0);
    step(1, 0, 1, 0, 32'hFFFFFFFC, 1, 48'hFFFF_0000_1234, 0);
    chk("pc8_wrap_depth3", 124'(pc83), 124'(32'h00000004));
    chk("pc8_wrap_depth2", 124'(pc82), 124'(32'h00000004));
    chk("ae_payload_depth3", 124'({ae3, d3}), 124'({1'b1, 48'hFFFF_0000_1234}));

    phase = "random";
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(63) != 0), 1'($urandom_range(31) == 0),
           1'($urandom_range(3) != 0), 1'($urandom_range(1)), $urandom,
           1'($urandom_range(1)), {16'($urandom), $urandom}, 1'($urandom_range(2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
